// File: rtl/radix4_controller.sv
// Radix-4 multiplier control FSM: ENTER-driven operand load, ITER add/shift
// iterations with a watchdog on flag. Optional ENTER debounce via DEBOUNCE_EN.
module radix4_controller #(
  parameter int ITER       = 4,
  parameter int DEB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter,
  input  logic       flag,
  output logic [4:0] ld,
  output logic [4:0] sel,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOADA = 4'd1,
    S_WAITB = 4'd2,
    S_LOADB = 4'd3,
    S_CLR   = 4'd4,
    S_CALC  = 4'd5,
    S_SHIFT = 4'd6,
    S_CHECK = 4'd7,
    S_DONE  = 4'd8,
    S_ERR   = 4'd9
  } state_t;

  localparam logic [2:0] ITER_W = 3'(ITER);

  if (ITER < 1 || ITER > 7 || DEB_CYCLES < 2) begin : g_param_chk
    $error("radix4_controller: need 1 <= ITER <= 7 and DEB_CYCLES >= 2");
  end

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_wd;
  logic       r_sync1;
  logic       r_sync2;
  logic       r_prev;
  logic       w_lvl;
  logic       w_ent_p;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= enter;
      r_sync2 <= r_sync1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int            DW      = $clog2(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

  logic [DW-1:0] r_deb_cnt;
  logic          r_deb;

  // Level only flips after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_deb_cnt <= '0;
      r_deb     <= 1'b0;
    end else if (r_sync2 == r_deb) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt == DEB_MAX) begin
      r_deb_cnt <= '0;
      r_deb     <= r_sync2;
    end else begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  assign w_lvl = r_deb;
`else
  assign w_lvl = r_sync2;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_prev <= 1'b0;
    else      r_prev <= w_lvl;
  end

  assign w_ent_p = w_lvl & ~r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    r_wd <= 3'd0;
    else if (r_state == S_CLR)   r_wd <= 3'd0;
    else if (r_state == S_SHIFT) r_wd <= r_wd + 3'd1;
  end

  always_comb begin
    w_next = S_IDLE;
    unique case (r_state)
      S_IDLE:  w_next = w_ent_p ? S_LOADA : S_IDLE;
      S_LOADA: w_next = S_WAITB;
      S_WAITB: w_next = w_ent_p ? S_LOADB : S_WAITB;
      S_LOADB: w_next = S_CLR;
      S_CLR:   w_next = S_CALC;
      S_CALC:  w_next = S_SHIFT;
      S_SHIFT: w_next = S_CHECK;
      S_CHECK: begin
        if (flag)                 w_next = S_DONE;
        else if (r_wd == ITER_W)  w_next = S_ERR;
        else                      w_next = S_CALC;
      end
      S_DONE:  w_next = w_ent_p ? S_IDLE : S_DONE;
      S_ERR:   w_next = w_ent_p ? S_IDLE : S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  // Moore decode: ld {disp,cnt,P,B,A}, sel {rsv,disp,cnt,B,P}
  always_comb begin
    ld   = 5'b00000;
    sel  = 5'b00000;
    busy = 1'b0;
    done = 1'b0;
    err  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        ld  = 5'b10000;
        sel = 5'b01000;
      end
      S_LOADA: ld = 5'b00001;
      S_WAITB: begin
        ld  = 5'b10000;
        sel = 5'b01000;
      end
      S_LOADB: ld = 5'b00010;
      S_CLR: begin
        ld   = 5'b01100;
        busy = 1'b1;
      end
      S_CALC: begin
        ld   = 5'b00100;
        sel  = 5'b00001;
        busy = 1'b1;
      end
      S_SHIFT: begin
        ld   = 5'b01010;
        sel  = 5'b00110;
        busy = 1'b1;
      end
      S_CHECK: busy = 1'b1;
      S_DONE: begin
        ld   = 5'b10000;
        done = 1'b1;
      end
      S_ERR:   err = 1'b1;
      default: ld = 5'b00000;
    endcase
  end

endmodule

// File: tb/tb_radix4_controller.sv
// Directed bench for radix4_controller with a datapath counter model
// driving flag; debounce checks are built when DEBOUNCE_EN is defined.
module tb_radix4_controller;

`ifdef DEBOUNCE_EN
  localparam int ENT_LAT = 3 + 16;
`else
  localparam int ENT_LAT = 3;
`endif

  localparam logic [4:0] LD_IDLE  = 5'b10000;
  localparam logic [4:0] SEL_IDLE = 5'b01000;
  localparam logic [4:0] LD_LOADA = 5'b00001;
  localparam logic [4:0] LD_LOADB = 5'b00010;
  localparam logic [4:0] LD_CLR   = 5'b01100;
  localparam logic [4:0] LD_CALC  = 5'b00100;
  localparam logic [4:0] SEL_CALC = 5'b00001;
  localparam logic [4:0] LD_SHIFT = 5'b01010;
  localparam logic [4:0] SEL_SHFT = 5'b00110;

  logic       clk;
  logic       rst;
  logic       enter;
  logic       flag;
  logic [4:0] ld;
  logic [4:0] sel;
  logic       busy;
  logic       done;
  logic       err;

  int n_tests;
  int n_fail;
  int flag_mode;
  logic [2:0] m_cnt;

  radix4_controller #(.ITER(4), .DEB_CYCLES(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .enter (enter),
    .flag  (flag),
    .ld    (ld),
    .sel   (sel),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath iteration counter: load 4 on init, decrement on shift
  always @(posedge clk) begin
    if (ld[3]) m_cnt <= sel[2] ? m_cnt - 3'd1 : 3'd4;
  end

  always_comb begin
    flag = 1'b0;
    if (flag_mode == 0)      flag = (m_cnt == 3'd0);
    else if (flag_mode == 2) flag = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [4:0] l, input logic [4:0] s,
                            input int bound, output int n);
    n = 0;
    while (n <= bound) begin
      tick();
      n++;
      if (ld === l && sel === s) return;
    end
  endtask

  task automatic apply_reset();
    enter = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    repeat (ENT_LAT + 20) tick();
  endtask

  task automatic run_to_loadb();
    int n;
    enter = 1'b1;
    wait_state(LD_LOADA, 5'b00000, ENT_LAT + 10, n);
    n_tests++;
    if (n > ENT_LAT + 10) begin
      n_fail++;
      $display("FAIL run_to_loadb LOADA timeout after %0d cycles", n);
    end
    enter = 1'b0;
    repeat (ENT_LAT + 20) tick();
    enter = 1'b1;
    wait_state(LD_LOADB, 5'b00000, ENT_LAT + 10, n);
    n_tests++;
    if (n > ENT_LAT + 10) begin
      n_fail++;
      $display("FAIL run_to_loadb LOADB timeout after %0d cycles", n);
    end
    enter = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_tests++;
    if (ld !== LD_IDLE) begin
      n_fail++;
      $display("FAIL reset_ld got %b want %b", ld, LD_IDLE);
    end
    n_tests++;
    if (sel !== SEL_IDLE) begin
      n_fail++;
      $display("FAIL reset_sel got %b want %b", sel, SEL_IDLE);
    end
    n_tests++;
    if ({busy, done, err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 000", {busy, done, err});
    end
    tick();
    rst = 1'b1;
    repeat (5) tick();
    n_tests++;
    if (ld !== LD_IDLE || sel !== SEL_IDLE) begin
      n_fail++;
      $display("FAIL reset_idle_hold got %b/%b want %b/%b",
               ld, sel, LD_IDLE, SEL_IDLE);
    end
  endtask

  task automatic test_full_run();
    int n;
    int calc;
    int shift;
    apply_reset();
    flag_mode = 0;
    enter = 1'b1;
    wait_state(LD_LOADA, 5'b00000, ENT_LAT + 10, n);
    n_tests++;
    if (n !== ENT_LAT) begin
      n_fail++;
      $display("FAIL enter_to_loada got %0d want %0d", n, ENT_LAT);
    end
    tick();
    n_tests++;
    if (ld !== LD_IDLE || sel !== SEL_IDLE) begin
      n_fail++;
      $display("FAIL loada_one_cycle got %b/%b want %b/%b",
               ld, sel, LD_IDLE, SEL_IDLE);
    end
    enter = 1'b0;
    repeat (ENT_LAT + 20) tick();
    n_tests++;
    if (ld !== LD_IDLE || sel !== SEL_IDLE) begin
      n_fail++;
      $display("FAIL waitb_hold got %b/%b want %b/%b",
               ld, sel, LD_IDLE, SEL_IDLE);
    end
    enter = 1'b1;
    wait_state(LD_LOADB, 5'b00000, ENT_LAT + 10, n);
    n_tests++;
    if (n !== ENT_LAT) begin
      n_fail++;
      $display("FAIL enter_to_loadb got %0d want %0d", n, ENT_LAT);
    end
    enter = 1'b0;
    tick();
    n_tests++;
    if (ld !== LD_CLR || sel !== 5'b00000 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_after_loadb got %b/%b busy %b want %b/00000 busy 1",
               ld, sel, busy, LD_CLR);
    end
    n = 1;
    calc = 0;
    shift = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (ld === LD_CALC && sel === SEL_CALC) calc++;
      if (ld === LD_SHIFT && sel === SEL_SHFT) shift++;
    end
    n_tests++;
    if (n !== 14) begin
      n_fail++;
      $display("FAIL loadb_to_done got %0d want 14", n);
    end
    n_tests++;
    if (calc !== 4 || shift !== 4) begin
      n_fail++;
      $display("FAIL iter_pairs got calc %0d shift %0d want 4 4", calc, shift);
    end
    n_tests++;
    if (ld !== LD_IDLE || sel !== 5'b00000 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL done_outputs got %b/%b busy %b err %b want 10000/00000 0 0",
               ld, sel, busy, err);
    end
    repeat (ENT_LAT + 20) tick();
    n_tests++;
    if (done !== 1'b1 || ld !== LD_IDLE) begin
      n_fail++;
      $display("FAIL done_hold got done %b ld %b want 1 10000", done, ld);
    end
    enter = 1'b1;
    wait_state(LD_IDLE, SEL_IDLE, ENT_LAT + 10, n);
    n_tests++;
    if (n !== ENT_LAT || done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_to_idle got %0d cycles done %b want %0d 0",
               n, done, ENT_LAT);
    end
    enter = 1'b0;
  endtask

  task automatic test_held_enter();
    int la;
    int lb;
    apply_reset();
    la = 0;
    lb = 0;
    enter = 1'b1;
    repeat (50) begin
      tick();
      if (ld === LD_LOADA) la++;
      if (ld === LD_LOADB) lb++;
    end
    n_tests++;
    if (la !== 1 || lb !== 0) begin
      n_fail++;
      $display("FAIL held_enter got loada %0d loadb %0d want 1 0", la, lb);
    end
    n_tests++;
    if (ld !== LD_IDLE || sel !== SEL_IDLE || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL held_waitb got %b/%b busy %b want %b/%b 0",
               ld, sel, busy, LD_IDLE, SEL_IDLE);
    end
    enter = 1'b0;
  endtask

  task automatic test_err();
    int n;
    apply_reset();
    flag_mode = 1;
    run_to_loadb();
    n = 0;
    while (err !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    n_tests++;
    if (n !== 14) begin
      n_fail++;
      $display("FAIL loadb_to_err got %0d want 14", n);
    end
    n_tests++;
    if (ld !== 5'b00000 || sel !== 5'b00000 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL err_outputs got %b/%b busy %b done %b want 00000/00000 0 0",
               ld, sel, busy, done);
    end
    repeat (ENT_LAT + 20) tick();
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_hold got %b want 1", err);
    end
    enter = 1'b1;
    wait_state(LD_IDLE, SEL_IDLE, ENT_LAT + 10, n);
    n_tests++;
    if (n !== ENT_LAT || err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_to_idle got %0d cycles err %b want %0d 0",
               n, err, ENT_LAT);
    end
    enter = 1'b0;
    flag_mode = 0;
  endtask

  task automatic test_early_flag();
    int n;
    int calc;
    apply_reset();
    flag_mode = 2;
    run_to_loadb();
    n = 0;
    calc = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (ld === LD_CALC && sel === SEL_CALC) calc++;
    end
    n_tests++;
    if (n !== 5 || calc !== 1) begin
      n_fail++;
      $display("FAIL early_flag got %0d cycles %0d calc want 5 1", n, calc);
    end
    flag_mode = 0;
  endtask

  task automatic test_reset_midrun();
    int n;
    apply_reset();
    flag_mode = 0;
    run_to_loadb();
    wait_state(LD_CALC, SEL_CALC, 10, n);
    n_tests++;
    if (n !== 2) begin
      n_fail++;
      $display("FAIL loadb_to_calc got %0d want 2", n);
    end
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if (ld !== LD_IDLE || sel !== SEL_IDLE || {busy, done, err} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset got %b/%b flags %b want %b/%b 000",
               ld, sel, {busy, done, err}, LD_IDLE, SEL_IDLE);
    end
    tick();
    rst = 1'b1;
    repeat (ENT_LAT + 20) tick();
    n_tests++;
    if (ld !== LD_IDLE || sel !== SEL_IDLE || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle got %b/%b busy %b want %b/%b 0",
               ld, sel, busy, LD_IDLE, SEL_IDLE);
    end
  endtask

`ifdef DEBOUNCE_EN
  task automatic test_debounce();
    int n;
    int bad;
    apply_reset();
    bad = 0;
    enter = 1'b1;
    repeat (10) begin
      tick();
      if (ld !== LD_IDLE) bad++;
    end
    enter = 1'b0;
    repeat (40) begin
      tick();
      if (ld !== LD_IDLE) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL glitch_ignored got %0d non-idle cycles want 0", bad);
    end
    enter = 1'b1;
    wait_state(LD_LOADA, 5'b00000, 40, n);
    n_tests++;
    if (n !== 19) begin
      n_fail++;
      $display("FAIL debounce_latency got %0d want 19", n);
    end
    tick();
    enter = 1'b0;
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail = 0;
    flag_mode = 0;
    rst = 1'b0;
    enter = 1'b0;
    test_reset();
    test_full_run();
    test_held_enter();
    test_err();
    test_early_flag();
    test_reset_midrun();
`ifdef DEBOUNCE_EN
    test_debounce();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
